// File: rtl/sc_bus_pkg.sv
// sc_bus_pkg: shared state encoding and bus constants for the smartcard SRAM arbiter.
package sc_bus_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} sc_state_e;
   localparam int SC_DATA_W = 32;
   localparam int SC_STRB_W = 4;
   localparam int SC_REQ_M0 = 0;
   localparam int SC_REQ_M1 = 1;
endpackage

// File: rtl/sc_rr_arb2.sv
// sc_rr_arb2: combinational two-way round-robin picker; on a tie the requester not granted last wins.
module sc_rr_arb2
   import sc_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);
   assign grant[SC_REQ_M0] = req[SC_REQ_M0] & (~req[SC_REQ_M1] | last_grant);
   assign grant[SC_REQ_M1] = req[SC_REQ_M1] & (~req[SC_REQ_M0] | ~last_grant);
endmodule

// File: rtl/sc_mem_arbiter.sv
// sc_mem_arbiter: round-robin sharing of the single-port SRAM between the CPU (m0) and a DMA master (m1).
// Define SC_ARB_PROT_EN to confine m1 to the [PROT_BASE, PROT_BASE+PROT_SIZE) window.
module sc_mem_arbiter
   import sc_bus_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] PROT_BASE = 32'h0000_2000,
   parameter logic [ADDR_W-1:0] PROT_SIZE = 32'h0000_1000
) (
   input  logic                 clk_sc,
   input  logic                 resetn,
   input  logic                 m0_valid,
   input  logic [ADDR_W-1:0]    m0_addr,
   input  logic [SC_DATA_W-1:0] m0_wdata,
   input  logic [SC_STRB_W-1:0] m0_wstrb,
   output logic                 m0_ready,
   output logic [SC_DATA_W-1:0] m0_rdata,
   input  logic                 m1_valid,
   input  logic [ADDR_W-1:0]    m1_addr,
   input  logic [SC_DATA_W-1:0] m1_wdata,
   input  logic [SC_STRB_W-1:0] m1_wstrb,
   output logic                 m1_ready,
   output logic [SC_DATA_W-1:0] m1_rdata,
   output logic                 ram_en,
   output logic [SC_STRB_W-1:0] ram_we,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic [SC_DATA_W-1:0] ram_wdata,
   input  logic [SC_DATA_W-1:0] ram_rdata,
   output logic                 prot_err,
   output logic                 busy
);
`ifdef SC_ARB_PROT_EN
   localparam bit PROT_ON = 1'b1;
`else
   localparam bit PROT_ON = 1'b0;
`endif
   sc_state_e  state;
   logic [1:0] gnt;
   logic       last_grant, grant, blk, win_m1, blk_n;
   sc_rr_arb2 u_arb (.req({m1_valid, m0_valid}), .last_grant(last_grant), .grant(gnt));
   assign win_m1 = gnt[SC_REQ_M1];
   // Unsigned offset compare covers both the below-base and past-end cases in one test
   assign blk_n = PROT_ON && win_m1 && ((m1_addr - PROT_BASE) >= PROT_SIZE);
   assign m0_rdata = m0_ready ? ram_rdata : '0;
   assign m1_rdata = (m1_ready && !blk) ? ram_rdata : '0;
   always_ff @(posedge clk_sc or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         blk        <= 1'b0;
         ram_en     <= 1'b0;
         ram_we     <= '0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         m0_ready   <= 1'b0;
         m1_ready   <= 1'b0;
         prot_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|gnt) begin
               grant     <= win_m1;
               blk       <= blk_n;
               ram_en    <= !blk_n;
               ram_we    <= blk_n ? '0 : (win_m1 ? m1_wstrb : m0_wstrb);
               ram_addr  <= win_m1 ? m1_addr : m0_addr;
               ram_wdata <= win_m1 ? m1_wdata : m0_wdata;
               busy      <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               ram_en   <= 1'b0;
               ram_we   <= '0;
               m0_ready <= !grant;
               m1_ready <= grant;
               prot_err <= blk;
               state    <= RESP;
            end
            RESP: begin
               m0_ready   <= 1'b0;
               m1_ready   <= 1'b0;
               prot_err   <= 1'b0;
               busy       <= 1'b0;
               last_grant <= grant;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
